// File: rtl/ssd1331_ctrl_if.sv
// Host-side request channel of the SSD1331 controller: one start/ready
// handshake carrying mode, payload bytes and byte count.
interface ssd1331_ctrl_if #(
  parameter int MAX_BYTES = 4,
  parameter int NB_W      = $clog2(MAX_BYTES) + 1
);
  logic [1:0]             i_MODE;
  logic                   i_START;
  logic [8*MAX_BYTES-1:0] i_DATA;
  logic [NB_W-1:0]        i_NBYTES;
  logic                   o_READY;
  logic                   o_POWERED;
  logic                   o_ERR;

  // A request transfers on the i_CLK edge where i_START and o_READY are both
  // high; i_MODE/i_DATA/i_NBYTES are sampled on that edge only, and i_START
  // while o_READY is low is dropped without any response.
  modport master (
    output i_MODE, i_START, i_DATA, i_NBYTES,
    input  o_READY, o_POWERED, o_ERR
  );

  modport slave (
    input  i_MODE, i_START, i_DATA, i_NBYTES,
    output o_READY, o_POWERED, o_ERR
  );
endinterface

// File: rtl/ssd1331_ctrl.sv
// SSD1331 PmodOLED controller: power-up/power-down sequencing plus
// multi-byte SPI mode 3 command/data transactions under one CS assertion.
module ssd1331_ctrl #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 4,
  parameter int T_VDD     = 20,
  parameter int T_RES     = 3,
  parameter int T_VCC     = 100,
  parameter int T_OFF     = 100,
  parameter int NB_W      = $clog2(MAX_BYTES) + 1
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  ssd1331_ctrl_if.slave host,
  output logic         o_CS,
  output logic         o_MOSI,
  output logic         o_SCK,
  output logic         o_DC,
  output logic         o_RES,
  output logic         o_VCCEN,
  output logic         o_PMODEN,
  output logic [3:0]   o_STATE
);

  localparam int TM1  = (T_VDD > T_RES) ? T_VDD : T_RES;
  localparam int TM2  = (TM1 > T_VCC) ? TM1 : T_VCC;
  localparam int TM3  = (TM2 > T_OFF) ? TM2 : T_OFF;
  localparam int TMAX = (TM3 > CLK_DIV) ? TM3 : CLK_DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = 8 * MAX_BYTES;

  typedef enum logic [3:0] {
    S_OFF, S_PU_VDD, S_PU_RESLO, S_PU_RESHI, S_PU_VCC, S_IDLE,
    S_SPI_SETUP, S_SPI_LO, S_SPI_HI, S_SPI_HOLD, S_PD_VCC
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmr_q;
  logic [2:0]      bit_q;
  logic [NB_W-1:0] byte_q;
  logic [NB_W-1:0] nb_q;
  logic [DW-1:0]   data_q;
  logic            ready_q, powered_q, err_q;
  logic            cs_q, sck_q, mosi_q, dc_q, res_q, vccen_q, pmoden_q;

  logic            accept;
  logic            bad_n;
  logic            last_bit;
  logic [DW-1:0]   data_shr;

  assign accept   = ready_q & host.i_START;
  assign bad_n    = (host.i_NBYTES == '0) || (host.i_NBYTES > NB_W'(MAX_BYTES));
  assign last_bit = (bit_q == 3'd0) && (byte_q == nb_q - NB_W'(1));
  assign data_shr = data_q >> 8;

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q   <= S_OFF;
      tmr_q     <= '0;
      bit_q     <= 3'd7;
      byte_q    <= '0;
      nb_q      <= '0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      powered_q <= 1'b0;
      err_q     <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      res_q     <= 1'b1;
      vccen_q   <= 1'b0;
      pmoden_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_OFF: begin
          if (accept) begin
            if (host.i_MODE == 2'b00) begin
              state_q  <= S_PU_VDD;
              pmoden_q <= 1'b1;
              ready_q  <= 1'b0;
              tmr_q    <= TW'(T_VDD - 1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_PU_VDD: begin
          if (tmr_q == '0) begin
            state_q <= S_PU_RESLO;
            res_q   <= 1'b0;
            tmr_q   <= TW'(T_RES - 1);
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_PU_RESLO: begin
          if (tmr_q == '0) begin
            state_q <= S_PU_RESHI;
            res_q   <= 1'b1;
            tmr_q   <= TW'(T_RES - 1);
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_PU_RESHI: begin
          if (tmr_q == '0) begin
            state_q <= S_PU_VCC;
            vccen_q <= 1'b1;
            tmr_q   <= TW'(T_VCC - 1);
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_PU_VCC: begin
          if (tmr_q == '0) begin
            state_q   <= S_IDLE;
            powered_q <= 1'b1;
            ready_q   <= 1'b1;
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_IDLE: begin
          if (accept) begin
            if ((host.i_MODE == 2'b00) || (host.i_MODE[1] && bad_n)) begin
              err_q <= 1'b1;
            end else if (host.i_MODE == 2'b01) begin
              state_q   <= S_PD_VCC;
              vccen_q   <= 1'b0;
              powered_q <= 1'b0;
              ready_q   <= 1'b0;
              tmr_q     <= TW'(T_OFF - 1);
            end else begin
              // First bit is presented together with the CS fall.
              state_q <= S_SPI_SETUP;
              ready_q <= 1'b0;
              cs_q    <= 1'b0;
              sck_q   <= 1'b1;
              dc_q    <= host.i_MODE[0];
              data_q  <= host.i_DATA;
              mosi_q  <= host.i_DATA[7];
              nb_q    <= host.i_NBYTES;
              bit_q   <= 3'd7;
              byte_q  <= '0;
              tmr_q   <= TW'(CLK_DIV - 1);
            end
          end
        end
        S_SPI_SETUP: begin
          if (tmr_q == '0) begin
            state_q <= S_SPI_LO;
            sck_q   <= 1'b0;
            tmr_q   <= TW'(CLK_DIV - 1);
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_SPI_LO: begin
          if (tmr_q == '0) begin
            state_q <= S_SPI_HI;
            sck_q   <= 1'b1;
            tmr_q   <= TW'(CLK_DIV - 1);
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_SPI_HI: begin
          if (tmr_q == '0) begin
            tmr_q <= TW'(CLK_DIV - 1);
            if (last_bit) begin
              state_q <= S_SPI_HOLD;
              cs_q    <= 1'b1;
              mosi_q  <= 1'b0;
            end else begin
              // MOSI advances only on the SCK falling edge.
              state_q <= S_SPI_LO;
              sck_q   <= 1'b0;
              if (bit_q == 3'd0) begin
                bit_q  <= 3'd7;
                byte_q <= byte_q + NB_W'(1);
                data_q <= data_shr;
                mosi_q <= data_shr[7];
              end else begin
                bit_q       <= bit_q - 3'd1;
                data_q[7:0] <= {data_q[6:0], 1'b0};
                mosi_q      <= data_q[6];
              end
            end
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_SPI_HOLD: begin
          if (tmr_q == '0) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else tmr_q <= tmr_q - TW'(1);
        end
        S_PD_VCC: begin
          if (tmr_q == '0) begin
            state_q  <= S_OFF;
            pmoden_q <= 1'b0;
            ready_q  <= 1'b1;
          end else tmr_q <= tmr_q - TW'(1);
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign host.o_READY   = ready_q;
  assign host.o_POWERED = powered_q;
  assign host.o_ERR     = err_q;
  assign o_CS     = cs_q;
  assign o_MOSI   = mosi_q;
  assign o_SCK    = sck_q;
  assign o_DC     = dc_q;
  assign o_RES    = res_q;
  assign o_VCCEN  = vccen_q;
  assign o_PMODEN = pmoden_q;
  assign o_STATE  = state_q;

endmodule

// File: tb/tb_ssd1331_ctrl.sv
// Directed bench for ssd1331_ctrl: power sequencing timestamps, SPI framing
// and decoded bytes, rejected requests, busy-start filtering, mid-byte reset.
module tb_ssd1331_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int MAX_BYTES = 4;
  localparam int T_VDD     = 20;
  localparam int T_RES     = 3;
  localparam int T_VCC     = 100;
  localparam int T_OFF     = 100;
  localparam int NB_W      = $clog2(MAX_BYTES) + 1;
  localparam int DW        = 8 * MAX_BYTES;

  // pins = {cs, sck, mosi, res, vccen, pmoden, powered, ready}
  localparam logic [7:0] PINS_OFF = 8'b1101_0001;
  localparam logic [7:0] PINS_ON  = 8'b1101_1111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd1331_ctrl_if #(.MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) host_if ();

  logic       cs, mosi, sck, dc, res, vccen, pmoden;
  logic [3:0] state_dbg;
  logic [7:0] pins;

  ssd1331_ctrl #(
    .CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .T_VDD(T_VDD), .T_RES(T_RES),
    .T_VCC(T_VCC), .T_OFF(T_OFF), .NB_W(NB_W)
  ) dut (
    .i_CLK(clk), .i_RST(rst_n), .host(host_if),
    .o_CS(cs), .o_MOSI(mosi), .o_SCK(sck), .o_DC(dc), .o_RES(res),
    .o_VCCEN(vccen), .o_PMODEN(pmoden), .o_STATE(state_dbg)
  );

  assign pins = {cs, sck, mosi, res, vccen, pmoden, host_if.o_POWERED, host_if.o_READY};

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- driver ----------------
  // Raises i_START before edge T0 and drops it just after; caller's first
  // negedge afterwards observes the T0+1 values.
  task automatic request(input logic [1:0] mode, input logic [DW-1:0] data,
                         input logic [NB_W-1:0] n);
    @(negedge clk);
    host_if.i_MODE   = mode;
    host_if.i_DATA   = data;
    host_if.i_NBYTES = n;
    host_if.i_START  = 1'b1;
    @(posedge clk);
    #1;
    host_if.i_START  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pins !== PINS_OFF) begin n_bad++; $display("FAIL reset_pins got %b want %b", pins, PINS_OFF); end
    n_cmp++; if ({host_if.o_ERR, dc} !== 2'b00) begin n_bad++; $display("FAIL reset_err_dc got %b want 00", {host_if.o_ERR, dc}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (pins !== PINS_OFF) begin n_bad++; $display("FAIL reset_release_pins got %b want %b", pins, PINS_OFF); end
  endtask

  task automatic test_err(input string name, input logic [1:0] mode, input logic [NB_W-1:0] n,
                          input logic [7:0] exp_pins, input logic exp_dc);
    int bad_hold;
    request(mode, 32'hDEAD_BEEF, n);
    @(negedge clk);
    n_cmp++; if (host_if.o_ERR !== 1'b1) begin n_bad++; $display("FAIL %s_err_pulse got %b want 1", name, host_if.o_ERR); end
    n_cmp++; if ({pins, dc} !== {exp_pins, exp_dc}) begin n_bad++; $display("FAIL %s_pins got %b want %b", name, {pins, dc}, {exp_pins, exp_dc}); end
    bad_hold = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (host_if.o_ERR !== 1'b0 || {pins, dc} !== {exp_pins, exp_dc}) bad_hold++;
    end
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL %s_hold got %0d bad cycles want 0", name, bad_hold); end
  endtask

  task automatic test_power_on();
    int t_pm, t_rlo, t_rhi, t_vcc, t_rdy;
    logic rdy_j1;
    t_pm = -1; t_rlo = -1; t_rhi = -1; t_vcc = -1; t_rdy = -1; rdy_j1 = 1'bx;
    request(2'b00, '0, NB_W'(1));
    for (int j = 1; j <= 300 && t_rdy < 0; j++) begin
      @(negedge clk);
      if (j == 1) rdy_j1 = host_if.o_READY;
      if (t_pm < 0 && pmoden === 1'b1) t_pm = j;
      if (t_rlo < 0 && res === 1'b0) t_rlo = j;
      if (t_rlo >= 0 && t_rhi < 0 && res === 1'b1) t_rhi = j;
      if (t_vcc < 0 && vccen === 1'b1) t_vcc = j;
      if (t_rdy < 0 && host_if.o_READY === 1'b1) t_rdy = j;
    end
    n_cmp++; if (rdy_j1 !== 1'b0) begin n_bad++; $display("FAIL pu_busy got %b want 0", rdy_j1); end
    n_cmp++; if (t_pm != 1)   begin n_bad++; $display("FAIL pu_pmoden_t got %0d want 1", t_pm); end
    n_cmp++; if (t_rlo != 21) begin n_bad++; $display("FAIL pu_res_lo_t got %0d want 21", t_rlo); end
    n_cmp++; if (t_rhi != 24) begin n_bad++; $display("FAIL pu_res_hi_t got %0d want 24", t_rhi); end
    n_cmp++; if (t_vcc != 27) begin n_bad++; $display("FAIL pu_vccen_t got %0d want 27", t_vcc); end
    n_cmp++; if (t_rdy != 127) begin n_bad++; $display("FAIL pu_ready_t got %0d want 127 (0 = timeout)", t_rdy < 0 ? 0 : t_rdy); end
    n_cmp++; if (pins !== PINS_ON) begin n_bad++; $display("FAIL pu_final_pins got %b want %b", pins, PINS_ON); end
  endtask

  task automatic test_spi(input string name, input logic [1:0] mode, input logic [DW-1:0] data,
                          input logic [NB_W-1:0] n, input logic [31:0] exp_rx,
                          input int exp_cs_last, input int exp_rdy);
    int t_cs0, t_cs1, t_rdy, nrise, dc_bad, mosi_bad;
    logic prev_sck, prev_mosi;
    logic [31:0] rx;
    t_cs0 = -1; t_cs1 = -1; t_rdy = -1; nrise = 0; dc_bad = 0; mosi_bad = 0;
    prev_sck = 1'b1; prev_mosi = 1'b0; rx = '0;
    request(mode, data, n);
    for (int j = 1; j <= 1000 && t_rdy < 0; j++) begin
      @(negedge clk);
      if (cs === 1'b0) begin
        if (t_cs0 < 0) t_cs0 = j;
        t_cs1 = j;
        if (dc !== mode[0]) dc_bad++;
        if (prev_sck === 1'b0 && sck === 1'b1) begin rx = {rx[30:0], mosi}; nrise++; end
        if (j > 1 && mosi !== prev_mosi && !(prev_sck === 1'b1 && sck === 1'b0)) mosi_bad++;
      end else if (t_cs0 >= 0 && mosi !== 1'b0) mosi_bad++;
      if (t_rdy < 0 && host_if.o_READY === 1'b1) t_rdy = j;
      prev_sck = sck; prev_mosi = mosi;
    end
    n_cmp++; if (t_cs0 != 1) begin n_bad++; $display("FAIL %s_cs_fall got %0d want 1", name, t_cs0); end
    n_cmp++; if (t_cs1 != exp_cs_last) begin n_bad++; $display("FAIL %s_cs_last_low got %0d want %0d", name, t_cs1, exp_cs_last); end
    n_cmp++; if (nrise != 8 * int'(n)) begin n_bad++; $display("FAIL %s_sck_rises got %0d want %0d", name, nrise, 8 * int'(n)); end
    n_cmp++; if (rx !== exp_rx) begin n_bad++; $display("FAIL %s_rx got %h want %h", name, rx, exp_rx); end
    n_cmp++; if (dc_bad != 0) begin n_bad++; $display("FAIL %s_dc_held got %0d bad want 0", name, dc_bad); end
    n_cmp++; if (mosi_bad != 0) begin n_bad++; $display("FAIL %s_mosi_timing got %0d bad want 0", name, mosi_bad); end
    n_cmp++; if (t_rdy != exp_rdy) begin n_bad++; $display("FAIL %s_ready_t got %0d want %0d", name, t_rdy, exp_rdy); end
    n_cmp++; if ({pins, dc} !== {PINS_ON, mode[0]}) begin n_bad++; $display("FAIL %s_idle_pins got %b want %b", name, {pins, dc}, {PINS_ON, mode[0]}); end
  endtask

  task automatic test_power_off_busy();
    int t_vccl, t_pml, t_rdy, err_seen, restart;
    logic [2:0] j1;
    t_vccl = -1; t_pml = -1; t_rdy = -1; err_seen = 0; restart = 0; j1 = 'x;
    request(2'b01, '0, NB_W'(1));
    for (int j = 1; j <= 160; j++) begin
      @(negedge clk);
      if (j == 1) j1 = {vccen, host_if.o_POWERED, host_if.o_READY};
      if (t_vccl < 0 && vccen === 1'b0) t_vccl = j;
      if (t_pml < 0 && pmoden === 1'b0) t_pml = j;
      if (t_pml >= 0 && (pmoden !== 1'b0 || vccen !== 1'b0)) restart++;
      if (t_rdy < 0 && host_if.o_READY === 1'b1) t_rdy = j;
      if (host_if.o_ERR !== 1'b0) err_seen++;
      // Keep hammering i_START only while the controller is busy.
      host_if.i_MODE  = 2'($urandom_range(0, 3));
      host_if.i_START = (host_if.o_READY === 1'b0);
    end
    host_if.i_START = 1'b0;
    n_cmp++; if (j1 !== 3'b000) begin n_bad++; $display("FAIL pd_first_cycle got %b want 000", j1); end
    n_cmp++; if (t_pml != 101) begin n_bad++; $display("FAIL pd_pmoden_t got %0d want 101", t_pml); end
    n_cmp++; if (t_rdy != 101) begin n_bad++; $display("FAIL pd_ready_t got %0d want 101", t_rdy); end
    n_cmp++; if (restart != 0 || err_seen != 0) begin n_bad++; $display("FAIL pd_busy_ignored got restart=%0d err=%0d want 0/0", restart, err_seen); end
    n_cmp++; if (pins !== PINS_OFF) begin n_bad++; $display("FAIL pd_final_pins got %b want %b", pins, PINS_OFF); end
  endtask

  task automatic test_reset_mid();
    int nrise, found, bad_after;
    logic prev_sck;
    nrise = 0; found = 0; prev_sck = 1'b1; bad_after = 0;
    request(2'b11, 32'h0000_3CA5, NB_W'(2));
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (prev_sck === 1'b0 && sck === 1'b1) nrise++;
      prev_sck = sck;
      if (nrise == 12 && sck === 1'b0) begin found = 1; break; end
    end
    n_cmp++; if (found != 1 || cs !== 1'b0) begin n_bad++; $display("FAIL rm_reach_bit got found=%0d cs=%b want 1/0", found, cs); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({pins, dc} !== {PINS_OFF, 1'b0}) begin n_bad++; $display("FAIL rm_pins got %b want %b", {pins, dc}, {PINS_OFF, 1'b0}); end
    rst_n = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (pins !== PINS_OFF) bad_after++;
    end
    n_cmp++; if (bad_after != 0) begin n_bad++; $display("FAIL rm_no_resume got %0d bad cycles want 0", bad_after); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    host_if.i_START  = 1'b0;
    host_if.i_MODE   = 2'b00;
    host_if.i_DATA   = '0;
    host_if.i_NBYTES = '0;
    test_reset();
    test_err("cmd_while_off", 2'b10, NB_W'(1), PINS_OFF, 1'b0);
    test_err("off_while_off", 2'b01, NB_W'(1), PINS_OFF, 1'b0);
    test_power_on();
    test_err("on_while_on", 2'b00, NB_W'(1), PINS_ON, 1'b0);
    test_err("n_zero", 2'b10, NB_W'(0), PINS_ON, 1'b0);
    test_err("n_five", 2'b11, NB_W'(5), PINS_ON, 1'b0);
    test_spi("cmd_af", 2'b10, 32'h0000_00AF, NB_W'(1), 32'h0000_00AF, 68, 73);
    test_spi("data4", 2'b11, 32'h1234_5678, NB_W'(4), 32'h7856_3412, 260, 265);
    test_spi("cmd2_b2b", 2'b10, 32'h0000_A0FF, NB_W'(2), 32'h0000_FFA0, 132, 137);
    test_power_off_busy();
    test_power_on();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
